regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (wA, wD, wrEn feeding the 5-to-32 write-enable decoder) between two writeback requesters: port A (ALU writeback) and port B (load/memory writeback).
- Each port has a valid/ready handshake and a one-entry holding buffer.
- Age-then-round-robin arbitration picks one buffered write per cycle and drives registered write-port outputs.

Parameters:
- DW, 32, data width of a register write.
- AW, 5, register address width (32 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  port A write request valid.
- a_ready  output  1  port A can accept this cycle.
- a_addr  input  AW  port A destination register.
- a_data  input  DW  port A write data.
- b_valid  input  1  port B write request valid.
- b_ready  output  1  port B can accept this cycle.
- b_addr  input  AW  port B destination register.
- b_data  input  DW  port B write data.
- wA  output  AW  register-file write address (registered).
- wD  output  DW  register-file write data (registered).
- wrEn  output  1  register-file write enable (registered).
- busy  output  1  high while either holding buffer is full or wrEn is high.

Behaviour:
- Reset (rst_n low, asynchronous): wA=0, wD=0, wrEn=0, both buffers empty, older_a=0, older_b=0, rr_ptr=0 (A favoured), busy=0. a_ready and b_ready are 0 while rst_n is low and 1 after release.
- Reset asserted mid-operation drops all buffered writes. No partial write is issued.
- Acceptance: a transfer occurs on a rising edge when x_valid & x_ready. addr and data load into buf_x, and full_x is set.
- x_ready = !full_x | grant_x. A port accepts back-to-back with 1/cycle throughput when it wins every cycle.
- Arbitration is combinational on buffer state; the grant takes effect at the same edge:
  - Neither full: no grant; wrEn is 0 next cycle.
  - Only one full: grant it.
  - Both full, one older (loaded in a strictly earlier cycle): grant the older one.
  - Both full, same age: grant per rr_ptr (0 = A, 1 = B). rr_ptr flips to the loser after each same-age contested grant and is otherwise unchanged.
- Age tracking:
  - older_a is set when buf_a holds while buf_b loads.
  - older_a is cleared when buf_a is granted.
  - older_b is symmetric.
  - Both are cleared when their buffer empties.
- Output register: at a granting edge, wA/wD load the winner's addr/data and wrEn=1. At a non-granting edge, wrEn=0; wA/wD hold their last values.
- Latency: a request accepted at edge E0 and uncontended produces wrEn high from edge E1 to E2 (one cycle). Contended loser: +1 cycle per lost arbitration.
- Same-address writes from A and B are issued in acceptance order. Same-cycle acceptance follows rr_ptr. Later write wins in the register file.
- Simultaneous grant and new acceptance on the same port at one edge: buffer reloads with new entry, full stays 1, age flag is recomputed against the other buffer.
- No combinational path from x_valid to wA/wD/wrEn.

Optional Feature:
- Macro REGFILE_WR_ZERO_REG_EN.
- Defined: requests with addr==0 are accepted normally, but on grant wrEn stays 0 (r0 hardwired, write dropped; wA/wD still load). Dropped grants still count for rr_ptr and age updates.
- Undefined: address 0 is written like any other register.

Test Plan:
- Reset then A-only: a_valid=1, a_addr=5, a_data=0xDEADBEEF at edge 1 -> wrEn=1, wA=5, wD=0xDEADBEEF in cycle after edge 2; a_ready stays 1.
- Simultaneous same-age: A(addr 3, 0x11) and B(addr 3, 0x22) accepted at edge 1, rr_ptr=0 -> A issued after edge 2, B after edge 3. b_ready=0 during cycle after edge 1. rr_ptr=1 afterwards.
- Age priority: B(addr 7) accepted edge 1 while A blocked (A buffer full); A loads edge 2 -> B older and issued before A regardless of rr_ptr.
- Streaming both ports for 8 cycles -> wrEn continuously 1, A and B alternate, no entry lost or duplicated (scoreboard).
- Reset mid-operation: both buffers full, rst_n pulled low between edges -> wrEn, busy, full flags go 0 immediately; no write issued after release.
- With REGFILE_WR_ZERO_REG_EN: A(addr 0, 0x55) -> a_ready handshake completes, wrEn stays 0. Without the macro -> wrEn=1, wA=0, wD=0x55.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single register-file write port between two writeback requesters.
// Port A is ALU writeback and port B is load/memory writeback. Each port has a
// valid/ready handshake and a one-entry holding buffer. Every cycle one buffered
// write is picked: the older entry wins first, then round-robin between entries
// of the same age. The chosen write drives registered wA/wD/wrEn outputs.
//
// Optional feature macro: REGFILE_WR_ZERO_REG_EN
//   When defined, r0 is hardwired. A granted write to address 0 still loads
//   wA/wD, but wrEn stays low. The grant still consumes the buffer and still
//   updates the age flags and the round-robin pointer.
//   When undefined, address 0 is written like any other register.
module regfile_wr_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] wA,
  output logic [DW-1:0] wD,
  output logic          wrEn,
  output logic          busy
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } sel_e;

  logic          full_a;
  logic          full_b;
  logic [AW-1:0] buf_a_addr;
  logic [AW-1:0] buf_b_addr;
  logic [DW-1:0] buf_a_data;
  logic [DW-1:0] buf_b_data;
  logic          older_a;
  logic          older_b;
  logic          rr_ptr;

  sel_e          sel;
  logic          grant_a;
  logic          grant_b;
  logic          same_age;
  logic          acc_a;
  logic          acc_b;
  logic          hold_a;
  logic          hold_b;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          issue_en;

  // Pick the winner from buffer state only: older entry first, then rr_ptr.
  always_comb begin
    sel = SEL_NONE;
    if (full_a && full_b) begin
      if (older_a) begin
        sel = SEL_A;
      end else if (older_b) begin
        sel = SEL_B;
      end else if (rr_ptr) begin
        sel = SEL_B;
      end else begin
        sel = SEL_A;
      end
    end else if (full_a) begin
      sel = SEL_A;
    end else if (full_b) begin
      sel = SEL_B;
    end
  end

  // Handshake and retention terms. A buffer frees up on the same edge it is granted.
  always_comb begin
    grant_a  = (sel == SEL_A);
    grant_b  = (sel == SEL_B);
    same_age = full_a & full_b & ~older_a & ~older_b;
    a_ready  = rst_n & (~full_a | grant_a);
    b_ready  = rst_n & (~full_b | grant_b);
    acc_a    = a_valid & a_ready;
    acc_b    = b_valid & b_ready;
    hold_a   = full_a & ~grant_a;
    hold_b   = full_b & ~grant_b;
  end

  // Route the winning buffer to the write port and decide whether it really writes.
  always_comb begin
    win_addr = buf_a_addr;
    win_data = buf_a_data;
    if (sel == SEL_B) begin
      win_addr = buf_b_addr;
      win_data = buf_b_data;
    end
`ifdef REGFILE_WR_ZERO_REG_EN
    issue_en = (sel != SEL_NONE) && (win_addr != '0);
`else
    issue_en = (sel != SEL_NONE);
`endif
  end

  // Port A holding buffer: loads on acceptance, stays full only while it keeps losing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_a     <= 1'b0;
      buf_a_addr <= '0;
      buf_a_data <= '0;
    end else begin
      full_a <= acc_a | hold_a;
      if (acc_a) begin
        buf_a_addr <= a_addr;
        buf_a_data <= a_data;
      end
    end
  end

  // Port B holding buffer, symmetric with port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_b     <= 1'b0;
      buf_b_addr <= '0;
      buf_b_data <= '0;
    end else begin
      full_b <= acc_b | hold_b;
      if (acc_b) begin
        buf_b_addr <= b_addr;
        buf_b_data <= b_data;
      end
    end
  end

  // Age flags: an entry becomes older when it stays put while the other side loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_a <= 1'b0;
      older_b <= 1'b0;
    end else begin
      older_a <= hold_a & (acc_b | older_a);
      older_b <= hold_b & (acc_a | older_b);
    end
  end

  // Round-robin pointer moves to the loser only after a same-age contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (same_age) begin
      rr_ptr <= grant_a;
    end
  end

  // Registered write port: wA/wD follow the winner and hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wA   <= '0;
      wD   <= '0;
      wrEn <= 1'b0;
    end else begin
      wrEn <= issue_en;
      if (sel != SEL_NONE) begin
        wA <= win_addr;
        wD <= win_data;
      end
    end
  end

  assign busy = full_a | full_b | wrEn;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
// Self-checking bench for regfile_wr_arbiter. A reference model keeps each pending
// write with the edge number at which it was accepted. Arbitration compares those
// timestamps, and a round-robin bit breaks ties. Directed scenarios check fixed
// values, and a randomized run compares every output against the model each cycle.
// Honours REGFILE_WR_ZERO_REG_EN the same way the design does.
module tb_regfile_wr_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [AW-1:0] wA;
  logic [DW-1:0] wD;
  logic          wrEn;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_pa;
  bit            m_pb;
  logic [AW-1:0] m_aa;
  logic [AW-1:0] m_ba;
  logic [DW-1:0] m_ad;
  logic [DW-1:0] m_bd;
  int            m_ta;
  int            m_tb;
  bit            m_rr;
  int            m_edge;
  logic          exp_wren;
  logic [AW-1:0] exp_wa;
  logic [DW-1:0] exp_wd;
  logic          exp_a_ready;
  logic          exp_b_ready;
  logic          exp_busy;
  logic [DW-1:0] acc_q_a[$];
  logic [DW-1:0] acc_q_b[$];

  regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .wA      (wA),
    .wD      (wD),
    .wrEn    (wrEn),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner of the model's pending writes: 0 none, 1 port A, 2 port B.
  function automatic int pick();
    if (m_pa && m_pb) begin
      if (m_ta < m_tb) return 1;
      if (m_tb < m_ta) return 2;
      return m_rr ? 2 : 1;
    end
    if (m_pa) return 1;
    if (m_pb) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_pa = 0; m_pb = 0; m_rr = 0; m_edge = 0; m_ta = 0; m_tb = 0;
    m_aa = '0; m_ba = '0; m_ad = '0; m_bd = '0;
    exp_wren = 1'b0; exp_wa = '0; exp_wd = '0;
    exp_a_ready = 1'b1; exp_b_ready = 1'b1; exp_busy = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return at the negedge.
  task automatic drive_cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    int   w;
    logic take_a;
    logic take_b;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    w = pick();
    if (m_pa && m_pb && (m_ta == m_tb)) m_rr = (w == 1);
    take_a = av && exp_a_ready;
    take_b = bv && exp_b_ready;
    if (w != 0) begin
      exp_wa = (w == 1) ? m_aa : m_ba;
      exp_wd = (w == 1) ? m_ad : m_bd;
`ifdef REGFILE_WR_ZERO_REG_EN
      exp_wren = (exp_wa != '0);
`else
      exp_wren = 1'b1;
`endif
    end else begin
      exp_wren = 1'b0;
    end
    if (w == 1) m_pa = 0;
    if (w == 2) m_pb = 0;
    m_edge++;
    if (take_a) begin m_pa = 1; m_aa = aa; m_ad = ad; m_ta = m_edge; acc_q_a.push_back(ad); end
    if (take_b) begin m_pb = 1; m_ba = ba; m_bd = bd; m_tb = m_edge; acc_q_b.push_back(bd); end
    w = pick();
    exp_a_ready = !m_pa || (w == 1);
    exp_b_ready = !m_pb || (w == 2);
    exp_busy    = m_pa || m_pb || exp_wren;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 0; a_addr = '0; a_data = '0;
    b_valid = 0; b_addr = '0; b_data = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (wrEn !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wren: got %0b expected 0", wrEn); end
    n_checks++; if (wA !== '0) begin n_fail++; $display("[TB] FAIL reset_wa: got %0h expected 0", wA); end
    n_checks++; if (wD !== '0) begin n_fail++; $display("[TB] FAIL reset_wd: got %0h expected 0", wD); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_ready: got %0b expected 0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_b_ready: got %0b expected 0", b_ready); end
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_a_ready: got %0b expected 1", a_ready); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_b_ready: got %0b expected 1", b_ready); end
    @(negedge clk);
  endtask

  task automatic test_a_only();
    drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b0) begin n_fail++; $display("[TB] FAIL a_only_e1_wren: got %0b expected 0", wrEn); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL a_only_e1_ready: got %0b expected 1", a_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL a_only_e1_busy: got %0b expected 1", busy); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1) begin n_fail++; $display("[TB] FAIL a_only_e2_wren: got %0b expected 1", wrEn); end
    n_checks++; if (wA !== 5'd5) begin n_fail++; $display("[TB] FAIL a_only_e2_wa: got %0d expected 5", wA); end
    n_checks++; if (wD !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL a_only_e2_wd: got %0h expected deadbeef", wD); end
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL a_only_e2_ready: got %0b expected 1", a_ready); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b0) begin n_fail++; $display("[TB] FAIL a_only_e3_wren: got %0b expected 0", wrEn); end
    n_checks++; if (wA !== 5'd5) begin n_fail++; $display("[TB] FAIL a_only_e3_hold_wa: got %0d expected 5", wA); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL a_only_e3_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_same_age();
    drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL same_age_a_ready: got %0b expected 1", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL same_age_b_ready: got %0b expected 0", b_ready); end
    n_checks++; if (wrEn !== 1'b0) begin n_fail++; $display("[TB] FAIL same_age_e1_wren: got %0b expected 0", wrEn); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1 || wA !== 5'd3 || wD !== 32'h11) begin n_fail++;
      $display("[TB] FAIL same_age_first: got wrEn=%0b wA=%0d wD=%0h expected 1/3/11", wrEn, wA, wD); end
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL same_age_b_ready_e2: got %0b expected 1", b_ready); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1 || wA !== 5'd3 || wD !== 32'h22) begin n_fail++;
      $display("[TB] FAIL same_age_second: got wrEn=%0b wA=%0d wD=%0h expected 1/3/22", wrEn, wA, wD); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b0 || wD !== 32'h22) begin n_fail++;
      $display("[TB] FAIL same_age_idle: got wrEn=%0b wD=%0h expected 0/22", wrEn, wD); end
  endtask

  // Starts with rr favouring B; later B is older while rr favours A.
  task automatic test_age_priority();
    drive_cycle(1'b1, 5'd8, 32'hA1, 1'b1, 5'd7, 32'hB1);
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL age_rr_b_first: got a_ready=%0b b_ready=%0b expected 0/1", a_ready, b_ready); end
    drive_cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'hB2);
    n_checks++; if (wrEn !== 1'b1 || wD !== 32'hB1) begin n_fail++;
      $display("[TB] FAIL age_e2_wd: got wrEn=%0b wD=%0h expected 1/b1", wrEn, wD); end
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++;
      $display("[TB] FAIL age_e2_ready: got a_ready=%0b b_ready=%0b expected 1/0", a_ready, b_ready); end
    drive_cycle(1'b1, 5'd9, 32'hA2, 1'b0, '0, '0);
    n_checks++; if (wD !== 32'hA1 || wA !== 5'd8) begin n_fail++;
      $display("[TB] FAIL age_e3_wd: got wA=%0d wD=%0h expected 8/a1", wA, wD); end
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL age_e3_older_b: got a_ready=%0b b_ready=%0b expected 0/1", a_ready, b_ready); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1 || wA !== 5'd7 || wD !== 32'hB2) begin n_fail++;
      $display("[TB] FAIL age_e4_b_older_wins: got wrEn=%0b wA=%0d wD=%0h expected 1/7/b2", wrEn, wA, wD); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1 || wA !== 5'd9 || wD !== 32'hA2) begin n_fail++;
      $display("[TB] FAIL age_e5: got wrEn=%0b wA=%0d wD=%0h expected 1/9/a2", wrEn, wA, wD); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("[TB] FAIL age_drained: got wrEn=%0b busy=%0b expected 0/0", wrEn, busy); end
  endtask

  // Both ports stream for 8 cycles. The scoreboard checks per-port order, with no loss or duplication.
  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    logic          prev_tag;
    acc_q_a.delete();
    acc_q_b.delete();
    prev_tag = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) drive_cycle(1'b1, 5'(i + 1), 32'h0A00_0000 + i, 1'b1, 5'(i + 16), 32'hB000_0000 + i);
      else       drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      n_checks++;
      if ({wrEn, wA, wD, a_ready, b_ready, busy} !== {exp_wren, exp_wa, exp_wd, exp_a_ready, exp_b_ready, exp_busy}) begin
        n_fail++;
        $display("[TB] FAIL stream_model_c%0d: got %h expected %h", i,
                 {wrEn, wA, wD, a_ready, b_ready, busy}, {exp_wren, exp_wa, exp_wd, exp_a_ready, exp_b_ready, exp_busy});
      end
      if (i >= 1 && i < 8) begin
        n_checks++; if (wrEn !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_wren_c%0d: got %0b expected 1", i, wrEn); end
      end
      if (i >= 2 && i < 8) begin
        n_checks++; if (wD[31] === prev_tag) begin n_fail++; $display("[TB] FAIL stream_alternate_c%0d: got port %0b twice expected other", i, prev_tag); end
      end
      if (wrEn === 1'b1) begin
        prev_tag = wD[31];
        n_checks++;
        if (wD[31] == 1'b0) begin
          if (acc_q_a.size() == 0) begin n_fail++; $display("[TB] FAIL stream_dup_a: got %0h expected no write", wD); end
          else begin exp_d = acc_q_a.pop_front();
            if (wD !== exp_d) begin n_fail++; $display("[TB] FAIL stream_order_a: got %0h expected %0h", wD, exp_d); end end
        end else begin
          if (acc_q_b.size() == 0) begin n_fail++; $display("[TB] FAIL stream_dup_b: got %0h expected no write", wD); end
          else begin exp_d = acc_q_b.pop_front();
            if (wD !== exp_d) begin n_fail++; $display("[TB] FAIL stream_order_b: got %0h expected %0h", wD, exp_d); end end
        end
      end
    end
    n_checks++;
    if (acc_q_a.size() + acc_q_b.size() != 0) begin n_fail++;
      $display("[TB] FAIL stream_lost: got %0d unissued entries expected 0", acc_q_a.size() + acc_q_b.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 304; i++) begin
      if (i < 300)
        drive_cycle(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom(),
                    ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), $urandom());
      else
        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      n_checks++;
      if ({wrEn, wA, wD, a_ready, b_ready, busy} !== {exp_wren, exp_wa, exp_wd, exp_a_ready, exp_b_ready, exp_busy}) begin
        n_fail++;
        $display("[TB] FAIL random_c%0d: got %h expected %h", i,
                 {wrEn, wA, wD, a_ready, b_ready, busy}, {exp_wren, exp_wa, exp_wd, exp_a_ready, exp_b_ready, exp_busy});
      end
    end
  endtask

  task automatic test_zero_reg();
    logic exp_en;
`ifdef REGFILE_WR_ZERO_REG_EN
    exp_en = 1'b0;
`else
    exp_en = 1'b1;
`endif
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_ready: got %0b expected 1", a_ready); end
    drive_cycle(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_accepted: got busy=%0b expected 1", busy); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (wrEn !== exp_en) begin n_fail++; $display("[TB] FAIL zero_wren: got %0b expected %0b", wrEn, exp_en); end
    n_checks++; if (wA !== 5'd0 || wD !== 32'h55) begin n_fail++;
      $display("[TB] FAIL zero_wa_wd: got wA=%0d wD=%0h expected 0/55", wA, wD); end
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_idle_busy: got %0b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 5'd2, 32'hC1, 1'b1, 5'd3, 32'hC2);
    drive_cycle(1'b1, 5'd4, 32'hC3, 1'b0, '0, '0);
    n_checks++; if (wrEn !== 1'b1 || busy !== 1'b1) begin n_fail++;
      $display("[TB] FAIL rmid_pre: got wrEn=%0b busy=%0b expected 1/1", wrEn, busy); end
    a_valid = 1'b0;
    b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wrEn !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rmid_async: got wrEn=%0b busy=%0b expected 0/0", wrEn, busy); end
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++;
      $display("[TB] FAIL rmid_ready: got a_ready=%0b b_ready=%0b expected 0/0", a_ready, b_ready); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b0, '0, '0);
      n_checks++; if (wrEn !== 1'b0 || busy !== 1'b0 || wA !== '0) begin n_fail++;
        $display("[TB] FAIL rmid_after_c%0d: got wrEn=%0b busy=%0b wA=%0d expected 0/0/0", i, wrEn, busy, wA); end
    end
  endtask

  // Run all scenarios in order, then print the summary.
  initial begin
    model_reset();
    test_reset();
    test_a_only();
    test_same_age();
    test_age_priority();
    test_back_to_back();
    test_random();
    test_zero_reg();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
